// File: rtl/ysyx_23060072_dmem_resp.sv
// Data-memory responder: valid/ready request in, fixed-latency response out.
// Ports: clk/rst_n; req_* (valid, ready, wen, addr, wdata, wmask); rsp_* (valid, ready, rdata, err).
module ysyx_23060072_dmem_resp #(
  parameter int          AW        = 10,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [32:0] LIMIT  = 33'd4 << AW;
  localparam logic [3:0]  LAT_M1 =
    (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [2**AW];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_wen;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wmask;
  logic [31:0]   w_off;
  logic          w_inrng;
  logic [AW-1:0] w_idx;
  logic          w_do_wr;
  logic          w_unused;

  assign req_ready = rst_n && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;

  // With zero latency the access happens on the accept edge itself,
  // so it must use the live request rather than the latched copy.
  assign w_enter_resp = rst_n &&
    ((r_state == IDLE && w_accept && LATENCY == 0) ||
     (r_state == WAIT && r_cnt == 4'd0));

  assign w_wen   = (r_state == IDLE) ? req_wen   : r_wen;
  assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_wmask = (r_state == IDLE) ? req_wmask : r_wmask;

  // Wrapping subtraction: addresses below the base land far above LIMIT.
  assign w_off    = w_addr - BASE_ADDR;
  assign w_inrng  = {1'b0, w_off} < LIMIT;
  assign w_idx    = w_off[AW+1:2];
  assign w_do_wr  = w_enter_resp && w_wen && w_inrng;
  assign w_unused = ^w_off;

  assign rsp_valid = r_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_valid <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wen   <= req_wen;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_enter_resp) begin
        r_valid <= 1'b1;
        r_err   <= !w_inrng;
        r_rdata <= (!w_wen && w_inrng) ? r_mem[w_idx] : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060072_dmem_resp.sv
// Bench for ysyx_23060072_dmem_resp: three instances (latency 1, 0, 3),
// directed vector table, corner sequences and randomized model checks.
module tb_ysyx_23060072_dmem_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid, req_ready, req_wen;
  logic [2:0]  rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [31:0] rsp_rdata [3];
  logic [3:0]  req_wmask [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_23060072_dmem_resp #(
      .AW(10),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 0 : 3)),
      .BASE_ADDR(BASE)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_wen  (req_wen[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_wmask(req_wmask[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [3][1024];
  bit          known [3][1024];

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          hold;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [$];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Window is [BASE, BASE+4KiB) computed in 64-bit, no wraparound.
  function automatic bit in_win(input logic [31:0] a);
    longint unsigned x;
    x = 64'(a);
    return (x >= 64'(BASE)) && (x < 64'(BASE) + 64'd4096);
  endfunction

  task automatic model_op(input int k, input bit wen,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] m, output bit chk_rd,
                          output logic [31:0] exp_rd, output bit exp_err);
    int idx;
    chk_rd  = 1'b1;
    exp_rd  = 32'd0;
    exp_err = 1'b0;
    if (!in_win(addr)) begin
      exp_err = 1'b1;
    end else begin
      idx = int'((64'(addr) - 64'(BASE)) / 4);
      if (wen) begin
        for (int b = 0; b < 4; b++)
          if (m[b]) mdl[k][idx][8*b +: 8] = wd[8*b +: 8];
        if (m == 4'hF) known[k][idx] = 1'b1;
      end else begin
        exp_rd = mdl[k][idx];
        chk_rd = known[k][idx];
      end
    end
  endtask

  // Called and returns on a falling edge. While the DUT is busy the
  // request lines carry random stores that must be ignored.
  task automatic txn(input int k, input bit wen, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] m,
                     input int hold, input bit chk_rd,
                     input logic [31:0] exp_rd, input bit exp_err,
                     input string nm, output longint t_acc);
    int n;
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    req_wmask[k] = m;
    rsp_ready[k] = 1'b0;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " accept"}, 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    req_wen[k]   = 1'b1;
    req_addr[k]  = BASE + 32'($urandom_range(0, 15)) * 4;
    req_wdata[k] = $urandom;
    req_wmask[k] = 4'hF;
    n = 1;
    while (!rsp_valid[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(lat_of(k) + 1));
    for (int h = 0; h <= hold; h++) begin
      chk({nm, " valid"}, 32'(rsp_valid[k]), 32'd1);
      chk({nm, " err"}, 32'(rsp_err[k]), 32'(exp_err));
      chk({nm, " busy"}, 32'(req_ready[k]), 32'd0);
      if (chk_rd) chk({nm, " rdata"}, rsp_rdata[k], exp_rd);
      if (h == hold) rsp_ready[k] = 1'b1;
      else @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    req_valid[k] = 1'b0;
    chk({nm, " drop"}, 32'(rsp_valid[k]), 32'd0);
    chk({nm, " idle"}, 32'(req_ready[k]), 32'd1);
  endtask

  task automatic mtxn(input int k, input bit wen, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] m,
                      input int hold, input string nm,
                      output longint t_acc);
    bit          c;
    logic [31:0] e;
    bit          er;
    model_op(k, wen, addr, wd, m, c, e, er);
    txn(k, wen, addr, wd, m, hold, c, e, er, nm, t_acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    longint t;
    longint tp;
    bit          c;
    logic [31:0] e;
    bit          er;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_wen[k]   = 1'b0;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
      req_wmask[k] = 4'd0;
      rsp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d ready", k), 32'(req_ready[k]), 32'd0);
      chk($sformatf("rst%0d valid", k), 32'(rsp_valid[k]), 32'd0);
      chk($sformatf("rst%0d rdata", k), rsp_rdata[k], 32'd0);
      chk($sformatf("rst%0d err", k), 32'(rsp_err[k]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("rst%0d idle", k), 32'(req_ready[k]), 32'd1);

    tbl.push_back('{1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1, 0, 0});
    tbl.push_back('{0, 32'h8000_0010, 0, 4'h0, 0, 1, 32'hDEAD_BEEF, 0});
    tbl.push_back('{1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, 1, 0, 0});
    tbl.push_back('{1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 0, 1, 0, 0});
    tbl.push_back('{0, 32'h8000_0020, 0, 4'h0, 0, 1, 32'h11BB_33DD, 0});
    tbl.push_back('{0, 32'h8000_1000, 0, 4'h0, 0, 1, 0, 1});
    tbl.push_back('{1, 32'h8000_0000, 32'h0, 4'hF, 0, 1, 0, 0});
    tbl.push_back('{1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 0, 1, 0, 0});
    tbl.push_back('{1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 0, 1, 0, 1});
    tbl.push_back('{1, 32'h8000_1000, 32'h8765_4321, 4'hF, 0, 1, 0, 1});
    tbl.push_back('{0, 32'h8000_0000, 0, 4'h0, 0, 1, 32'h0, 0});
    tbl.push_back('{0, 32'h8000_0FFF, 0, 4'h0, 1, 1, 32'hCAFE_F00D, 0});
    tbl.push_back('{1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 0, 1, 0, 0});
    tbl.push_back('{0, 32'h8000_0022, 0, 4'h0, 5, 1, 32'h11BB_33DD, 0});
    tbl.push_back('{0, 32'h7FFF_FFFC, 0, 4'h0, 2, 1, 0, 1});

    foreach (tbl[i]) begin
      model_op(0, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].mask,
               c, e, er);
      txn(0, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].mask,
          tbl[i].hold, tbl[i].chk_rd, tbl[i].exp_rd, tbl[i].exp_err,
          $sformatf("vec%0d", i), t);
    end

    // Zero latency, back to back: one accept every two cycles.
    tp = 0;
    for (int i = 0; i < 6; i++) begin
      mtxn(1, (i < 3), BASE + 32'h100 + 32'(i % 3) * 4, $urandom, 4'hF,
           0, $sformatf("b2b%0d", i), t);
      if (i > 0) chk($sformatf("b2b%0d period", i), 32'(t - tp), 32'd20);
      tp = t;
    end

    // Reset while waiting: the pending store must not commit.
    mtxn(2, 1, 32'h8000_0040, 32'h0102_0304, 4'hF, 0, "pre", t);
    req_valid[2] = 1'b1;
    req_wen[2]   = 1'b1;
    req_addr[2]  = 32'h8000_0040;
    req_wdata[2] = 32'h5555_5555;
    req_wmask[2] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("wrst ready", 32'(req_ready[2]), 32'd0);
      chk("wrst valid", 32'(rsp_valid[2]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("wrst quiet", 32'(rsp_valid[2]), 32'd0);
    end
    mtxn(2, 0, 32'h8000_0040, 0, 4'h0, 0, "wrst load", t);

    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++)
        mtxn(k, 1, BASE + 32'(w) * 4, $urandom, 4'hF, 0,
             $sformatf("init%0d_%0d", k, w), t);

    for (int i = 0; i < 150; i++) begin
      int          k;
      int          sel;
      logic [31:0] a;
      k   = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      if (sel < 7)
        a = BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      else if (sel == 7)
        a = 32'h8000_1000 + 32'($urandom_range(0, 255)) * 4;
      else if (sel == 8)
        a = BASE - 32'($urandom_range(1, 64)) * 4;
      else
        a = $urandom;
      mtxn(k, $urandom_range(0, 1) == 1, a, $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, 3),
           $sformatf("rnd%0d", i), t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
